// File: rtl/actor_mover_if.sv
// Collision-probe handshake between the actor mover (master) and the
// collision lookup (slave). The lookup answers each request with ack and hit.
interface actor_mover_if;
  logic       probe_req;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic       probe_ack;
  logic       probe_hit;

  modport master (
    output probe_req, probe_x, probe_y,
    input  probe_ack, probe_hit
  );

  modport slave (
    input  probe_req, probe_x, probe_y,
    output probe_ack, probe_hit
  );
endinterface

// File: rtl/actor_mover.sv
// Button-driven sprite mover: owns the sprite position and room coordinates,
// steps once per TICK_DIV held cycles, checks collisions and flips rooms at edges.
module actor_mover #(
  parameter int TICK_DIV = 150000,
  parameter int STEP     = 1,
  parameter int X_MIN    = 128,
  parameter int X_MAX    = 768,
  parameter int Y_MIN    = 35,
  parameter int Y_MAX    = 515,
  parameter int SPR      = 16,
  parameter int MAP_W    = 4,
  parameter int MAP_H    = 4,
  parameter int START_X  = 439,
  parameter int START_Y  = 266,
  parameter int START_MX = 1,
  parameter int START_MY = 1,
  parameter int PROBE_TO = 15
) (
  input  logic          CLOCK_25,
  input  logic          reset,
  input  logic          i_btn_up,
  input  logic          i_btn_down,
  input  logic          i_btn_left,
  input  logic          i_btn_right,
  actor_mover_if.master probe,
  output logic [9:0]    o_x_pos,
  output logic [9:0]    o_y_pos,
  output logic [2:0]    o_map_x,
  output logic [2:0]    o_map_y,
  output logic [1:0]    o_facing,
  output logic          o_moving,
  output logic          o_room_changed
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(PROBE_TO + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PROBE_LAST = PW'(PROBE_TO - 1);

  localparam logic [9:0] STP = 10'(STEP);
  localparam logic [9:0] XLO = 10'(X_MIN);
  localparam logic [9:0] XHI = 10'(X_MAX - SPR);
  localparam logic [9:0] YLO = 10'(Y_MIN);
  localparam logic [9:0] YHI = 10'(Y_MAX - SPR);

  localparam logic [2:0] MX_LAST = 3'(MAP_W - 1);
  localparam logic [2:0] MY_LAST = 3'(MAP_H - 1);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_PROBE,
    S_COMMIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [TW-1:0] r_tick;
  logic [PW-1:0] r_pcnt;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [9:0]    r_cand_x;
  logic [9:0]    r_cand_y;
  logic [2:0]    r_mx;
  logic [2:0]    r_my;
  logic [1:0]    r_facing;
  logic          r_room_changed;

  logic [3:0]    w_pressed;
  logic          w_held;
  logic [1:0]    w_new_dir;

  logic          w_edge;
  logic          w_neighbour;
  logic [9:0]    w_cand_x;
  logic [9:0]    w_cand_y;
  logic [9:0]    w_jump_x;
  logic [9:0]    w_jump_y;
  logic [2:0]    w_jump_mx;
  logic [2:0]    w_jump_my;

  logic          w_latch;
  logic          w_tick_clr;
  logic          w_tick_inc;
  logic          w_load_cand;
  logic          w_jump;
  logic          w_pcnt_clr;
  logic          w_pcnt_inc;
  logic          w_commit;

  // Buttons are active-low and assumed debounced/synchronised upstream.
  // The vector is indexed by direction code so the latched facing selects its button.
  assign w_pressed = {~i_btn_right, ~i_btn_left, ~i_btn_down, ~i_btn_up};
  assign w_held    = w_pressed[r_facing];

  always_comb begin
    w_new_dir = D_RIGHT;
    if (w_pressed[D_LEFT])      w_new_dir = D_LEFT;
    else if (w_pressed[D_DOWN]) w_new_dir = D_DOWN;
    else if (w_pressed[D_UP])   w_new_dir = D_UP;
  end

  // Edge tests compare before subtracting so an underflowed value never reaches a register.
  always_comb begin
    w_edge      = 1'b0;
    w_neighbour = 1'b0;
    w_cand_x    = r_x;
    w_cand_y    = r_y;
    w_jump_x    = r_x;
    w_jump_y    = r_y;
    w_jump_mx   = r_mx;
    w_jump_my   = r_my;
    unique case (r_facing)
      D_UP: begin
        w_edge      = (r_y < (YLO + STP));
        w_neighbour = (r_my != 3'd0);
        w_cand_y    = r_y - STP;
        w_jump_y    = YHI;
        w_jump_my   = r_my - 3'd1;
      end
      D_DOWN: begin
        w_edge      = (({1'b0, r_y} + {1'b0, STP}) > {1'b0, YHI});
        w_neighbour = (r_my != MY_LAST);
        w_cand_y    = r_y + STP;
        w_jump_y    = YLO;
        w_jump_my   = r_my + 3'd1;
      end
      D_LEFT: begin
        w_edge      = (r_x < (XLO + STP));
        w_neighbour = (r_mx != 3'd0);
        w_cand_x    = r_x - STP;
        w_jump_x    = XHI;
        w_jump_mx   = r_mx - 3'd1;
      end
      D_RIGHT: begin
        w_edge      = (({1'b0, r_x} + {1'b0, STP}) > {1'b0, XHI});
        w_neighbour = (r_mx != MX_LAST);
        w_cand_x    = r_x + STP;
        w_jump_x    = XLO;
        w_jump_mx   = r_mx + 3'd1;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_tick_clr  = 1'b0;
    w_tick_inc  = 1'b0;
    w_load_cand = 1'b0;
    w_jump      = 1'b0;
    w_pcnt_clr  = 1'b0;
    w_pcnt_inc  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_pressed) begin
          w_latch     = 1'b1;
          w_tick_clr  = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_held) begin
          w_state_nxt = S_IDLE;
        end else if (r_tick == TICK_LAST) begin
          w_tick_clr = 1'b1;
          if (!w_edge) begin
            w_load_cand = 1'b1;
            w_pcnt_clr  = 1'b1;
            w_state_nxt = S_PROBE;
          end else if (w_neighbour) begin
            w_jump = 1'b1;
          end
        end else begin
          w_tick_inc = 1'b1;
        end
      end
      // Button release is deliberately not looked at here; it is honoured after the probe.
      S_PROBE: begin
        if (probe.probe_ack) begin
          w_state_nxt = probe.probe_hit ? S_HOLD : S_COMMIT;
        end else if (r_pcnt == PROBE_LAST) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_pcnt_inc = 1'b1;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = w_held ? S_HOLD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      r_tick         <= '0;
      r_pcnt         <= '0;
      r_facing       <= D_DOWN;
      r_x            <= 10'(START_X);
      r_y            <= 10'(START_Y);
      r_mx           <= 3'(START_MX);
      r_my           <= 3'(START_MY);
      r_room_changed <= 1'b0;
    end else begin
      r_room_changed <= w_jump;
      if (w_tick_clr)      r_tick <= '0;
      else if (w_tick_inc) r_tick <= r_tick + TW'(1);
      if (w_pcnt_clr)      r_pcnt <= '0;
      else if (w_pcnt_inc) r_pcnt <= r_pcnt + PW'(1);
      if (w_latch) r_facing <= w_new_dir;
      if (w_jump) begin
        r_x  <= w_jump_x;
        r_y  <= w_jump_y;
        r_mx <= w_jump_mx;
        r_my <= w_jump_my;
      end else if (w_commit) begin
        r_x <= r_cand_x;
        r_y <= r_cand_y;
      end
    end
  end

  // Candidate is pure data: only meaningful while a probe is outstanding.
  always_ff @(posedge CLOCK_25) begin
    if (w_load_cand) begin
      r_cand_x <= w_cand_x;
      r_cand_y <= w_cand_y;
    end
  end

  assign probe.probe_req = (r_state == S_PROBE);
  assign probe.probe_x   = r_cand_x;
  assign probe.probe_y   = r_cand_y;

  assign o_x_pos        = r_x;
  assign o_y_pos        = r_y;
  assign o_map_x        = r_mx;
  assign o_map_y        = r_my;
  assign o_facing       = r_facing;
  assign o_moving       = (r_state != S_IDLE);
  assign o_room_changed = r_room_changed;

endmodule

// File: tb/tb_actor_mover.sv
// Randomised bench for actor_mover against a step-level movement model:
// random presses/probe answers, then long traversals to reach room edges and clamps.
module tb_actor_mover;
  localparam int TICK_DIV = 4;
  localparam int STEP     = 1;
  localparam int PROBE_TO = 15;
  localparam int X_MIN = 128, X_MAX = 768, Y_MIN = 35, Y_MAX = 515, SPR = 16;
  localparam int MAP_W = 4, MAP_H = 4;
  localparam int START_X = 439, START_Y = 266, START_MX = 1, START_MY = 1;
  localparam int K_PROBE = 0, K_JUMP = 1, K_CLAMP = 2;

  logic       CLOCK_25 = 1'b0;
  logic       reset    = 1'b1;
  logic       btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
  logic [9:0] x_pos, y_pos;
  logic [2:0] map_x, map_y;
  logic [1:0] facing;
  logic       moving, room_changed;

  actor_mover_if pif ();

  actor_mover #(.TICK_DIV(TICK_DIV), .STEP(STEP), .PROBE_TO(PROBE_TO)) dut (
    .CLOCK_25      (CLOCK_25),
    .reset         (reset),
    .i_btn_up      (btn_up),
    .i_btn_down    (btn_down),
    .i_btn_left    (btn_left),
    .i_btn_right   (btn_right),
    .probe         (pif),
    .o_x_pos       (x_pos),
    .o_y_pos       (y_pos),
    .o_map_x       (map_x),
    .o_map_y       (map_y),
    .o_facing      (facing),
    .o_moving      (moving),
    .o_room_changed(room_changed)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int cyc = 0;
  always @(posedge CLOCK_25) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int m_x, m_y, m_mx, m_my;
  int due;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bit index = direction code: 0 up, 1 down, 2 left, 3 right.
  task automatic set_btn(input logic [3:0] pr);
    btn_up    = ~pr[0];
    btn_down  = ~pr[1];
    btn_left  = ~pr[2];
    btn_right = ~pr[3];
  endtask

  function automatic int pick_dir(input logic [3:0] pr);
    if (pr[2]) return 2;
    if (pr[1]) return 1;
    if (pr[0]) return 0;
    return 3;
  endfunction

  task automatic model_plan(input int d, output int kind, output int cx, output int cy);
    cx = m_x; cy = m_y; kind = K_PROBE;
    case (d)
      0: if (m_y - STEP < Y_MIN) kind = (m_my > 0) ? K_JUMP : K_CLAMP; else cy = m_y - STEP;
      1: if (m_y + STEP > Y_MAX - SPR) kind = (m_my < MAP_H - 1) ? K_JUMP : K_CLAMP; else cy = m_y + STEP;
      2: if (m_x - STEP < X_MIN) kind = (m_mx > 0) ? K_JUMP : K_CLAMP; else cx = m_x - STEP;
      default: if (m_x + STEP > X_MAX - SPR) kind = (m_mx < MAP_W - 1) ? K_JUMP : K_CLAMP; else cx = m_x + STEP;
    endcase
  endtask

  task automatic model_jump(input int d);
    case (d)
      0: begin m_y = Y_MAX - SPR; m_my--; end
      1: begin m_y = Y_MIN;       m_my++; end
      2: begin m_x = X_MAX - SPR; m_mx--; end
      default: begin m_x = X_MIN; m_mx++; end
    endcase
  endtask

  // While holding between steps: nothing visible may change; stray acks are injected.
  task automatic idle_until(input int k);
    bit bad = 1'b0;
    while (cyc < k) begin
      if (pif.probe_req !== 1'b0 || room_changed !== 1'b0 || moving !== 1'b1 ||
          x_pos !== 10'(m_x) || y_pos !== 10'(m_y)) bad = 1'b1;
      pif.probe_ack = ($urandom_range(0, 3) == 0);
      pif.probe_hit = 1'($urandom);
      @(negedge CLOCK_25);
    end
    pif.probe_ack = 1'b0;
    chk("hold_quiet", 32'(bad), 0);
  endtask

  task automatic probe_hold(input int k, input int cx, input int cy);
    bit bad = 1'b0;
    while (cyc < k) begin
      if (pif.probe_req !== 1'b1 || pif.probe_x !== 10'(cx) || pif.probe_y !== 10'(cy) ||
          x_pos !== 10'(m_x)) bad = 1'b1;
      pif.probe_ack = 1'b0;
      pif.probe_hit = 1'($urandom);
      @(negedge CLOCK_25);
    end
    chk("probe_stable", 32'(bad), 0);
  endtask

  task automatic do_step(input int d, input int mode, input bit rel_ok, output bit released);
    int kind, cx, cy, rsp, dly, a;
    bit hit, rel;
    released = 1'b0;
    idle_until(due);
    model_plan(d, kind, cx, cy);
    if (kind == K_JUMP) begin
      model_jump(d);
      chk("rc_pulse", 32'(room_changed), 1);
      chk("jump_x", 32'(x_pos), m_x);
      chk("jump_y", 32'(y_pos), m_y);
      chk("jump_mx", 32'(map_x), m_mx);
      chk("jump_my", 32'(map_y), m_my);
      chk("jump_noprobe", 32'(pif.probe_req), 0);
      @(negedge CLOCK_25);
      chk("rc_single", 32'(room_changed), 0);
      due = due + TICK_DIV;
    end else if (kind == K_CLAMP) begin
      chk("clamp_x", 32'(x_pos), m_x);
      chk("clamp_y", 32'(y_pos), m_y);
      chk("clamp_map", 32'({map_x, map_y}), 32'({3'(m_mx), 3'(m_my)}));
      chk("clamp_noprobe", 32'(pif.probe_req), 0);
      chk("clamp_norc", 32'(room_changed), 0);
      due = due + TICK_DIV;
    end else begin
      chk("probe_req", 32'(pif.probe_req), 1);
      chk("probe_x", 32'(pif.probe_x), cx);
      chk("probe_y", 32'(pif.probe_y), cy);
      rsp = (mode == 0) ? $urandom_range(0, 9) : 0;
      if (rsp == 9) begin
        probe_hold(due + PROBE_TO - 1, cx, cy);
        chk("to_last_req", 32'(pif.probe_req), 1);
        @(negedge CLOCK_25);
        chk("to_drop", 32'(pif.probe_req), 0);
        chk("to_x", 32'(x_pos), m_x);
        chk("to_y", 32'(y_pos), m_y);
        due = due + PROBE_TO + TICK_DIV;
      end else begin
        dly = (mode == 0) ? $urandom_range(0, 3) : 0;
        probe_hold(due + dly, cx, cy);
        hit = (rsp >= 6);
        rel = rel_ok && !hit && ($urandom_range(0, 2) == 0);
        pif.probe_ack = 1'b1;
        pif.probe_hit = hit;
        if (rel) set_btn(4'b0000);
        a = cyc + 1;
        @(negedge CLOCK_25);
        pif.probe_ack = 1'b0;
        pif.probe_hit = 1'($urandom);
        chk("ack_no_move_yet", 32'(x_pos), m_x);
        chk("req_after_ack", 32'(pif.probe_req), 0);
        if (hit) begin
          chk("hit_moving", 32'(moving), 1);
          due = a + TICK_DIV;
        end else begin
          @(negedge CLOCK_25);
          m_x = cx; m_y = cy;
          chk("commit_x", 32'(x_pos), m_x);
          chk("commit_y", 32'(y_pos), m_y);
          if (rel) begin
            chk("rel_after_commit", 32'(moving), 0);
            released = 1'b1;
          end
          due = a + 1 + TICK_DIV;
        end
      end
    end
  endtask

  task automatic session(input logic [3:0] pr, input int nsteps, input int mode);
    int d;
    bit rel;
    logic [3:0] only;
    d = pick_dir(pr);
    rel = 1'b0;
    set_btn(pr);
    due = cyc + 1 + TICK_DIV;
    @(negedge CLOCK_25);
    chk("facing", 32'(facing), d);
    chk("moving_on", 32'(moving), 1);
    for (int i = 0; i < nsteps && !rel; i++) begin
      do_step(d, mode, (mode == 0) && (i == nsteps - 1), rel);
      if (i == 0 && !rel) begin
        only = 4'b0000;
        only[d] = 1'b1;
        set_btn(only);
      end
    end
    if (!rel) begin
      set_btn(4'b0000);
      @(negedge CLOCK_25);
    end
    chk("moving_off", 32'(moving), 0);
    repeat (3) @(negedge CLOCK_25);
    chk("idle_x", 32'(x_pos), m_x);
    chk("idle_y", 32'(y_pos), m_y);
    chk("idle_req", 32'(pif.probe_req), 0);
  endtask

  task automatic check_start(input string tag);
    chk({tag, "_x"}, 32'(x_pos), START_X);
    chk({tag, "_y"}, 32'(y_pos), START_Y);
    chk({tag, "_mx"}, 32'(map_x), START_MX);
    chk({tag, "_my"}, 32'(map_y), START_MY);
    chk({tag, "_face"}, 32'(facing), 1);
    chk({tag, "_req"}, 32'(pif.probe_req), 0);
    chk({tag, "_rc"}, 32'(room_changed), 0);
    chk({tag, "_mov"}, 32'(moving), 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.probe_ack = 1'b0;
    pif.probe_hit = 1'b0;
    m_x = START_X; m_y = START_Y; m_mx = START_MX; m_my = START_MY;
    repeat (3) @(negedge CLOCK_25);
    check_start("rst");
    reset = 1'b0;
    @(negedge CLOCK_25);

    // Two buttons with priority, then release of the losing one mid-hold.
    session(4'b0101, 3, 1);

    for (int s = 0; s < 30; s++)
      session(4'($urandom_range(1, 15)), $urandom_range(1, 6), 0);

    // Walk into the room edges: left jump, left clamp, up jump, down jump, up jump.
    session(4'b0100, (m_x - X_MIN) + 1, 1);
    session(4'b0100, (m_x - X_MIN) + 2, 1);
    session(4'b1000, 2, 1);
    session(4'b0001, (m_y - Y_MIN) + 1, 1);
    session(4'b0010, 1, 1);
    session(4'b0001, 1, 1);

    // Reset while a probe is outstanding.
    set_btn(4'b1000);
    due = cyc + 1 + TICK_DIV;
    @(negedge CLOCK_25);
    idle_until(due);
    chk("pre_rst_req", 32'(pif.probe_req), 1);
    reset = 1'b1;
    set_btn(4'b0000);
    @(negedge CLOCK_25);
    check_start("midrst");
    reset = 1'b0;
    m_x = START_X; m_y = START_Y; m_mx = START_MX; m_my = START_MY;
    repeat (2) @(negedge CLOCK_25);
    check_start("postrst");

    // From the reset position, right with clean acks: 440 then 441.
    session(4'b1000, 2, 1);
    chk("final_x", 32'(x_pos), START_X + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/actor_mover.md
ACTOR_MOVER -- requirements
Module: actor_mover

Interface
REQ-001 Parameter TICK_DIV, 150000, CLOCK_25 cycles a direction is held per movement step (range 2..2^20).
REQ-002 Parameter STEP, 1, pixels moved per committed step (range 1..8).
REQ-003 Parameters X_MIN/X_MAX, 128/768, Y_MIN/Y_MAX, 35/515, visible-area bounds in sync-counter coordinates.
REQ-004 Parameter SPR, 16, sprite edge length in pixels.
REQ-005 Parameters MAP_W/MAP_H, 4/4, room grid size (each range 1..8).
REQ-006 Parameters START_X/START_Y, 439/266, START_MX/START_MY, 1/1, reset position and reset room.
REQ-007 Parameter PROBE_TO, 15, maximum cycles to wait for probe_ack.
REQ-008 CLOCK_25  in  1  system clock, 25 MHz.
REQ-009 reset  in  1  asynchronous, active-high.
REQ-010 btn_up, btn_down, btn_left, btn_right  in  1 each  direction buttons, active-low.
REQ-011 probe_ack  in  1  collision-lookup response valid.
REQ-012 probe_hit  in  1  candidate position collides; valid only with probe_ack.
REQ-013 probe_req  out  1  collision-lookup request.
REQ-014 probe_x, probe_y  out  10 each  candidate position under test.
REQ-015 x_pos, y_pos  out  10 each  committed sprite top-left position.
REQ-016 map_x, map_y  out  3 each  current room coordinates.
REQ-017 facing  out  2  last direction: 0 up, 1 down, 2 left, 3 right.
REQ-018 moving  out  1  high whenever the state is not IDLE.
REQ-019 room_changed  out  1  single-cycle pulse on room transition.

Function
REQ-020 The block shall own the position registers; there is no position feedback input.
REQ-021 States shall be IDLE, HOLD, PROBE and COMMIT.
REQ-022 IDLE: on any pressed button, latch the direction with priority left > down > up > right, update facing, clear the tick counter and enter HOLD.
REQ-023 HOLD: if the latched button is released, go to IDLE; otherwise increment the tick counter. Other buttons are ignored.
REQ-024 HOLD: when the counter reaches TICK_DIV-1, clear it and compute the candidate position, moving STEP pixels along the latched direction.
REQ-025 Edge, left or up: a candidate below X_MIN or Y_MIN is an edge event.
REQ-026 Edge, right or down: a candidate above X_MAX-SPR or Y_MAX-SPR is an edge event.
REQ-027 Edge event with a neighbouring room present:
- the axis coordinate jumps to the opposite edge (X_MAX-SPR, X_MIN, Y_MAX-SPR or Y_MIN);
- map_x/map_y changes by ±1;
- room_changed pulses for one cycle;
- no probe is issued;
- the state returns to HOLD.
REQ-028 Edge event at map boundary (map coordinate 0, or MAP_W-1/MAP_H-1): no move and no probe; the state returns to HOLD (clamp).
REQ-029 Non-edge candidate: enter PROBE and drive probe_req=1, probe_x and probe_y, held stable until probe_ack or timeout.
REQ-030 PROBE, probe_ack with probe_hit=1: discard the candidate and go to HOLD.
REQ-031 PROBE, probe_ack with probe_hit=0: go to COMMIT.
REQ-032 PROBE, no probe_ack within PROBE_TO cycles: treat as a hit.
REQ-033 COMMIT: copy the candidate into x_pos/y_pos in one cycle, then go to HOLD (or to IDLE if the latched button is released).
REQ-034 Latency: x_pos/y_pos change on the second clock edge after the cycle probe_ack is sampled high with probe_hit=0.
REQ-035 A button release during PROBE shall not abort the probe; the release is evaluated after PROBE/COMMIT.
REQ-036 probe_req shall be low in every state except PROBE; probe_ack outside PROBE is ignored.
REQ-037 Position arithmetic shall be 10-bit unsigned; underflow is detected before subtraction, so no wrap-around is ever visible on x_pos/y_pos.

Reset
REQ-038 While reset is high, outputs shall be: x_pos=START_X, y_pos=START_Y, map_x=START_MX, map_y=START_MY, facing=1 (down), state IDLE, counter 0, probe_req=0, room_changed=0, moving=0.
REQ-039 Reset asserted mid-PROBE or mid-HOLD shall abandon the operation immediately; no pending commit survives.

Verification (TICK_DIV=4, STEP=1, PROBE_TO=15, other parameters default)
REQ-040 Hold btn_right low, ack every probe with hit=0 -> probe_req each 4th HOLD cycle with probe_x=440; x_pos=440 two edges after ack; then 441.
REQ-041 Hold btn_left at x_pos=128, map_x=1 -> x_pos=752, map_x=0, one-cycle room_changed, no probe_req; next edge at map_x=0 -> x_pos stays 128.
REQ-042 Probe answered with hit=1 -> x_pos unchanged; state HOLD; next probe 4 cycles later with the same probe_x.
REQ-043 Probe never acked -> probe_req drops after 15 cycles; position unchanged.
REQ-044 btn_left and btn_up pressed together from IDLE -> facing=2 and motion in x only; release btn_up alone -> no effect.
REQ-045 Reset pulsed while probe_req=1 -> next cycle probe_req=0, x_pos=439, y_pos=266, map=(1,1), moving=0.
